wb_mem_arbiter: RTL and testbench
=================================

Name: wb_mem_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the single `wishbone` link to `physical_memory` between the instruction-cache port (I) and the data-cache port (D) inside `mp3_top`.
- Uses round-robin arbitration with a registered grant, and holds a grant for the whole bus cycle, from CYC rise to CYC fall.
- A per-cycle watchdog flags a slave that never answers.

Parameters:
ADDR_WIDTH, 28, line address width (byte address bits [31:4])
DATA_WIDTH, 128, cache-line data width
SEL_WIDTH, 16, byte-select width (DATA_WIDTH/8)
TIMEOUT, 1024, cycles without ACK/RTY before timeout is flagged

Ports:
Clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_cyc, i_stb, i_we  in  1 each  I-master cycle/strobe/write
i_adr  in  ADDR_WIDTH  I-master address
i_dat_m  in  DATA_WIDTH  I-master write data
i_sel  in  SEL_WIDTH  I-master byte selects
i_ack, i_rty  out  1 each  I-master acknowledge/retry
i_dat_s  out  DATA_WIDTH  I-master read data
d_cyc, d_stb, d_we, d_adr, d_dat_m, d_sel  in  as I-port  D-master request
d_ack, d_rty  out  1 each  D-master acknowledge/retry
d_dat_s  out  DATA_WIDTH  D-master read data
m_cyc, m_stb, m_we  out  1 each  to memory slave
m_adr  out  ADDR_WIDTH  to memory slave
m_dat_m  out  DATA_WIDTH  to memory slave
m_sel  out  SEL_WIDTH  to memory slave
m_ack, m_rty  in  1 each  from memory slave
m_dat_s  in  DATA_WIDTH  from memory slave
timeout  out  1  one-cycle pulse on watchdog expiry
busy  out  1  high while any grant is held

Behaviour:
- Interface: one clock, Clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, last=D (so I wins the first tie), wdog=0.
  - All outputs 0: m_*, i_ack/rty, d_ack/rty, timeout, busy.
- States:
  - IDLE: no grant.
  - GNT_I: I owns the bus.
  - GNT_D: D owns the bus.
- IDLE transitions:
  - Only i_cyc=1 → GNT_I.
  - Only d_cyc=1 → GNT_D.
  - Both high → grant the port not equal to last.
  - Neither high → stay in IDLE.
  - The transition happens on the Clk edge.
- last is updated when a grant is taken.
- GNT_x, while x_cyc=1: stay in the state.
- GNT_x, when x_cyc=0: return to IDLE. This leaves one mandatory idle turnaround cycle with m_cyc=0.
- Routing (combinational from the registered state):
  - In GNT_x: m_cyc/stb/we/adr/dat_m/sel = x's signals; x_ack=m_ack; x_rty=m_rty; x_dat_s=m_dat_s.
  - The ungranted master sees ack=rty=0. Its dat_s = m_dat_s (don't-care).
  - In IDLE: m_cyc=m_stb=m_we=0; m_adr, m_dat_m, m_sel = 0.
- Latency: a request that is first high in cycle N in IDLE drives m_cyc in cycle N+1. The arbiter adds no latency to ACK.
- A master must hold cyc/stb/adr stable until ack. The arbiter does not buffer requests.
- Back-to-back requests from the same master while the other is idle:
  - The master drops CYC → IDLE.
  - It re-raises CYC → regranted after the turnaround cycle.
- Starvation bound: one completed cycle of the other master.
- Watchdog:
  - wdog counts cycles with m_stb=1 and m_ack=m_rty=0.
  - Cleared on ack, rty, or IDLE.
  - timeout pulses 1 for the one cycle in which wdog reaches TIMEOUT-1.
  - The counter then saturates; no further pulses until cleared.
  - The grant is not revoked.
- busy = (state != IDLE).
- Reset mid-cycle: all outputs drop asynchronously and the FSM returns to IDLE. Masters see ack=0.
- Simultaneous m_ack and x_cyc fall in the same cycle: the ack still passes through. State → IDLE at the next edge.

Test Plan:
- Reset with rst_n=0 while i_cyc=d_cyc=1 → m_cyc=0, busy=0. After release, I granted first: m_adr=i_adr=28'h0000010 in the next cycle.
- I read alone: i_adr=28'h0000020; slave acks 3 cycles later with m_dat_s=128'hDEAD…BEEF → i_ack=1 that cycle, i_dat_s matches, d_ack=0.
- Contention: both request continuously for 4 transactions → grants alternate I,D,I,D. m_cyc=0 for exactly 1 cycle between them.
- D write: d_we=1, d_sel=16'hFFFF, d_dat_m=128'h0123… → m_we=1, m_sel=16'hFFFF and m_dat_m match while in GNT_D. Ack routed to d_ack only.
- Slave never acks, TIMEOUT=8 → timeout pulses once, 8 cycles after m_stb rise. busy stays 1. A late ack completes normally.
- Reset asserted mid-D-cycle → m_cyc falls asynchronously (before next Clk edge). The next grant goes to I.

Source files
------------

// File: rtl/wb_mem_arbiter.sv
// Two-master / one-slave Wishbone arbiter sharing the physical-memory link
// between the instruction-cache (I) and data-cache (D) ports. Round-robin on
// ties, grant held for the whole bus cycle, watchdog on an unresponsive slave.
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | no grant; m_* driven to zero
// GNT_I | I-master owns the bus until i_cyc falls
// GNT_D | D-master owns the bus until d_cyc falls
module wb_mem_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int SEL_WIDTH  = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  Clk,
  input  logic                  rst_n,
  input  logic                  i_cyc,
  input  logic                  i_stb,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_adr,
  input  logic [DATA_WIDTH-1:0] i_dat_m,
  input  logic [SEL_WIDTH-1:0]  i_sel,
  output logic                  i_ack,
  output logic                  i_rty,
  output logic [DATA_WIDTH-1:0] i_dat_s,
  input  logic                  d_cyc,
  input  logic                  d_stb,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_adr,
  input  logic [DATA_WIDTH-1:0] d_dat_m,
  input  logic [SEL_WIDTH-1:0]  d_sel,
  output logic                  d_ack,
  output logic                  d_rty,
  output logic [DATA_WIDTH-1:0] d_dat_s,
  output logic                  m_cyc,
  output logic                  m_stb,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_adr,
  output logic [DATA_WIDTH-1:0] m_dat_m,
  output logic [SEL_WIDTH-1:0]  m_sel,
  input  logic                  m_ack,
  input  logic                  m_rty,
  input  logic [DATA_WIDTH-1:0] m_dat_s,
  output logic                  timeout,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  // last_q remembers who was granted most recently; the other port wins a tie
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  // Counter is one bit wider than needed for TIMEOUT-1 so it can park at
  // TIMEOUT after the pulse and never re-trigger until cleared.
  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
  localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;

  // State, round-robin pointer and watchdog registers
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= LAST_D;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  // Grant decision: only IDLE arbitrates, a grant lasts until its cyc falls
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (i_cyc && (!d_cyc || (last_q == LAST_D))) begin
          state_d = GNT_I;
          last_d  = LAST_I;
        end else if (d_cyc) begin
          state_d = GNT_D;
          last_d  = LAST_D;
        end
      end
      GNT_I:   if (!i_cyc) state_d = IDLE;
      GNT_D:   if (!d_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus routing from the registered grant; no added latency on ack/rty
  always_comb begin
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_adr   = '0;
    m_dat_m = '0;
    m_sel   = '0;
    i_ack   = 1'b0;
    i_rty   = 1'b0;
    d_ack   = 1'b0;
    d_rty   = 1'b0;
    unique case (state_q)
      GNT_I: begin
        m_cyc   = i_cyc;
        m_stb   = i_stb;
        m_we    = i_we;
        m_adr   = i_adr;
        m_dat_m = i_dat_m;
        m_sel   = i_sel;
        i_ack   = m_ack;
        i_rty   = m_rty;
      end
      GNT_D: begin
        m_cyc   = d_cyc;
        m_stb   = d_stb;
        m_we    = d_we;
        m_adr   = d_adr;
        m_dat_m = d_dat_m;
        m_sel   = d_sel;
        d_ack   = m_ack;
        d_rty   = m_rty;
      end
      default: ;
    endcase
  end

  // Watchdog: count stalled strobe cycles, pulse once, then saturate
  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
    if ((state_q == IDLE) || m_ack || m_rty) begin
      wdog_d = '0;
    end else if (m_stb) begin
      if (wdog_q == WDOG_LAST) timeout_d = 1'b1;
      if (wdog_q < WDOG_MAX)   wdog_d = wdog_q + WDOG_ONE;
    end
  end

  // Read data is broadcast; only the granted master's ack qualifies it
  assign i_dat_s = m_dat_s;
  assign d_dat_s = m_dat_s;
  assign timeout = timeout_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: directed scenarios followed by a randomized
// two-master run checked by a queue scoreboard and a reference slave.
module tb_wb_mem_arbiter;
  localparam int AW  = 28;
  localparam int DW  = 128;
  localparam int SW  = 16;
  localparam int TO  = 8;
  localparam int NTX = 40;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } txn_t;

  logic          Clk = 1'b0;
  logic          rst_n;
  logic          i_cyc, i_stb, i_we, i_ack, i_rty;
  logic [AW-1:0] i_adr;
  logic [DW-1:0] i_dat_m, i_dat_s;
  logic [SW-1:0] i_sel;
  logic          d_cyc, d_stb, d_we, d_ack, d_rty;
  logic [AW-1:0] d_adr;
  logic [DW-1:0] d_dat_m, d_dat_s;
  logic [SW-1:0] d_sel;
  logic          m_cyc, m_stb, m_we, m_ack, m_rty;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat_m, m_dat_s;
  logic [SW-1:0] m_sel;
  logic          timeout, busy;

  wb_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .rst_n(rst_n),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat_m(i_dat_m), .i_sel(i_sel),
    .i_ack(i_ack), .i_rty(i_rty), .i_dat_s(i_dat_s),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_dat_m(d_dat_m), .d_sel(d_sel),
    .d_ack(d_ack), .d_rty(d_rty), .d_dat_s(d_dat_s),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_m(m_dat_m), .m_sel(m_sel),
    .m_ack(m_ack), .m_rty(m_rty), .m_dat_s(m_dat_s),
    .timeout(timeout), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic sb_on    = 1'b0;
  txn_t q_i[$];
  txn_t q_d[$];
  int   served_i = 0, served_d = 0;
  int   wait_i = 0, wait_d = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference slave read data: a fixed function of the line address
  function automatic logic [DW-1:0] rd_data(input logic [AW-1:0] a);
    return {a, 4'h1, ~a, 4'h2, a ^ 28'h0F0F0F0, 4'h3, a + 28'd7, 4'h4};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  task automatic check_txn(input string nm, input txn_t t, input logic [DW-1:0] rdat);
    chk({nm, "_adr"}, m_adr, t.adr);
    chk({nm, "_we"}, m_we, t.we);
    if (t.we) begin
      chk({nm, "_wdat"}, m_dat_m, t.dat);
      chk({nm, "_sel"}, m_sel, t.sel);
    end else begin
      chk({nm, "_rdat"}, rdat, rd_data(t.adr));
    end
  endtask

  // Scoreboard monitor: pops expected transactions whenever a master is acked
  initial begin : monitor
    txn_t t;
    forever begin
      @(negedge Clk);
      if (sb_on) begin
        chk("ack_route", {i_ack | d_ack, i_ack & d_ack}, {m_ack, 1'b0});
        chk("no_timeout", timeout, 1'b0);
        if (i_ack) begin
          chk("sb_i_nonempty", q_i.size() != 0, 1'b1);
          if (q_i.size() != 0) begin
            t = q_i.pop_front();
            check_txn("i", t, i_dat_s);
          end
          served_i++;
          wait_i = 0;
          if (q_d.size() != 0) begin
            wait_d++;
            chk("starve_d", wait_d <= 1, 1'b1);
          end
        end
        if (d_ack) begin
          chk("sb_d_nonempty", q_d.size() != 0, 1'b1);
          if (q_d.size() != 0) begin
            t = q_d.pop_front();
            check_txn("d", t, d_dat_s);
          end
          served_d++;
          wait_d = 0;
          if (q_i.size() != 0) begin
            wait_i++;
            chk("starve_i", wait_i <= 1, 1'b1);
          end
        end
      end
    end
  end

  logic          lg_busy[18];
  logic          lg_cyc[18];
  logic [AW-1:0] lg_adr[18];
  int            act[2], idle[2], issued[2];
  txn_t          cur[2];

  initial begin : stim
    logic ai, ad, mc, busy_drop, s_req, sl_have;
    logic s_ack[2];
    logic [AW-1:0] s_adr;
    int nruns, gap, pulses, first_at, sl_dly, cyc_n;
    txn_t t;

    rst_n = 1'b0;
    i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = 28'h0000010; i_dat_m = '0; i_sel = '0;
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b0; d_adr = 28'h0000ABC; d_dat_m = '0; d_sel = '0;
    m_ack = 1'b0; m_rty = 1'b0; m_dat_s = '0;

    // reset with both masters requesting
    repeat (2) @(posedge Clk);
    smp();
    chk("rst_m_cyc", m_cyc, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_adr", m_adr, '0);
    chk("rst_timeout", timeout, 1'b0);
    tick(); rst_n = 1'b1;
    smp(); chk("rel_idle", busy, 1'b0);
    tick(); smp();
    chk("first_grant_i", m_adr, 28'h0000010);
    chk("first_grant_cyc", m_cyc, 1'b1);
    tick(); i_cyc = 1'b0; i_stb = 1'b0;
    tick(); smp(); chk("turnaround", busy, 1'b0);
    tick(); smp(); chk("then_grant_d", m_adr, 28'h0000ABC);
    tick(); d_cyc = 1'b0; d_stb = 1'b0;
    tick(); tick();

    // contention: both masters re-request immediately after every ack
    i_adr = 28'h0000100; d_adr = 28'h0000200;
    i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
    for (int k = 0; k < 18; k++) begin
      smp();
      lg_busy[k] = busy; lg_cyc[k] = m_cyc; lg_adr[k] = m_adr;
      ai = i_ack; ad = d_ack; mc = m_cyc && m_stb;
      tick();
      if (m_ack) m_ack = 1'b0; else if (mc) m_ack = 1'b1;
      if (ai) begin i_cyc = 1'b0; i_stb = 1'b0; end
      else if (!i_cyc) begin i_cyc = 1'b1; i_stb = 1'b1; end
      if (ad) begin d_cyc = 1'b0; d_stb = 1'b0; end
      else if (!d_cyc) begin d_cyc = 1'b1; d_stb = 1'b1; end
    end
    nruns = 0; gap = 0;
    for (int k = 1; k < 18; k++) begin
      if (lg_busy[k] && !lg_busy[k-1]) begin
        if (nruns < 4) begin
          chk("cont_grant", lg_adr[k], (nruns % 2 == 0) ? 28'h0000100 : 28'h0000200);
          if (nruns > 0) chk("cont_gap", gap, 1);
        end
        nruns++;
        gap = 0;
      end else if (!lg_busy[k]) begin
        gap++;
        if (nruns > 0) chk("gap_m_cyc", lg_cyc[k], 1'b0);
      end
    end
    chk("cont_runs", nruns >= 4, 1'b1);
    i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0; m_ack = 1'b0;
    tick(); tick();

    // I read alone, retry and ack routed only to I
    i_we = 1'b0; i_adr = 28'h0000020; i_cyc = 1'b1; i_stb = 1'b1;
    smp(); chk("lat_not_yet", m_cyc, 1'b0);
    tick(); smp();
    chk("i_read_adr", m_adr, 28'h0000020);
    chk("i_read_cyc", m_cyc, 1'b1);
    tick(); m_rty = 1'b1;
    smp(); chk("i_rty", i_rty, 1'b1); chk("d_rty_masked", d_rty, 1'b0);
    tick(); m_rty = 1'b0;
    tick(); m_ack = 1'b1; m_dat_s = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    smp();
    chk("i_ack", i_ack, 1'b1);
    chk("i_dat_s", i_dat_s, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
    chk("d_ack_masked", d_ack, 1'b0);
    tick(); m_ack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
    tick(); tick();

    // D write
    i_dat_m = 128'h5555_5555_5555_5555_5555_5555_5555_5555; i_sel = 16'h0001;
    d_we = 1'b1; d_sel = 16'hFFFF; d_adr = 28'h0000300;
    d_dat_m = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    d_cyc = 1'b1; d_stb = 1'b1;
    tick(); smp();
    chk("d_wr_we", m_we, 1'b1);
    chk("d_wr_sel", m_sel, 16'hFFFF);
    chk("d_wr_dat", m_dat_m, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("d_wr_adr", m_adr, 28'h0000300);
    tick(); m_ack = 1'b1;
    smp(); chk("d_wr_ack", d_ack, 1'b1); chk("d_wr_i_ack", i_ack, 1'b0);
    tick(); m_ack = 1'b0; d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0;
    tick(); tick();

    // watchdog: slave silent, pulse 8 cycles after strobe rise, grant kept
    i_we = 1'b0; i_adr = 28'h0000040; i_cyc = 1'b1; i_stb = 1'b1;
    pulses = 0; first_at = -1; busy_drop = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick(); smp();
      if (timeout) begin
        pulses++;
        if (first_at < 0) first_at = k - 1;
      end
      if (!busy) busy_drop = 1'b1;
    end
    chk("wdog_pulses", pulses, 1);
    chk("wdog_offset", first_at, 8);
    chk("wdog_busy_kept", busy_drop, 1'b0);
    tick(); m_ack = 1'b1;
    smp(); chk("late_ack", i_ack, 1'b1);
    tick(); m_ack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
    tick(); tick();

    // asynchronous reset in the middle of a D cycle
    d_adr = 28'h0000500; d_cyc = 1'b1; d_stb = 1'b1;
    tick(); smp(); chk("mid_d_grant", m_cyc, 1'b1);
    tick(); m_ack = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_m_cyc", m_cyc, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_d_ack", d_ack, 1'b0);
    m_ack = 1'b0; i_adr = 28'h0000600; i_cyc = 1'b1; i_stb = 1'b1;
    tick(); rst_n = 1'b1;
    tick(); smp(); chk("post_rst_grant_i", m_adr, 28'h0000600);
    tick(); i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
    tick(); tick(); tick();

    // randomized two-master traffic against the scoreboard
    for (int p = 0; p < 2; p++) begin
      act[p] = 0; idle[p] = 0; issued[p] = 0; cur[p] = '0;
    end
    sl_have = 1'b0; sl_dly = 0; cyc_n = 0;
    sb_on = 1'b1;
    while (!((issued[0] == NTX) && (issued[1] == NTX) && (act[0] == 0) && (act[1] == 0)) && (cyc_n < 5000)) begin
      smp();
      s_ack[0] = i_ack; s_ack[1] = d_ack;
      s_req = m_cyc && m_stb; s_adr = m_adr;
      tick();
      cyc_n++;
      if (m_ack) begin
        m_ack = 1'b0;
        sl_have = 1'b0;
      end else if (s_req) begin
        if (!sl_have) begin
          sl_have = 1'b1;
          sl_dly = int'($urandom_range(0, 3));
        end
        if (sl_dly == 0) begin
          m_ack = 1'b1;
          m_dat_s = rd_data(s_adr);
        end else begin
          sl_dly--;
        end
      end else begin
        sl_have = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (act[p] != 0) begin
          if (s_ack[p]) begin
            act[p] = 0;
            idle[p] = int'($urandom_range(0, 3));
          end
        end else if (idle[p] > 0) begin
          idle[p]--;
        end else if (issued[p] < NTX) begin
          t.adr = 28'($urandom);
          t.we  = 1'($urandom_range(0, 1));
          t.dat = {$urandom, $urandom, $urandom, $urandom};
          t.sel = 16'($urandom);
          cur[p] = t;
          if (p == 0) q_i.push_back(t); else q_d.push_back(t);
          issued[p]++;
          act[p] = 1;
        end
      end
      i_cyc = (act[0] != 0); i_stb = (act[0] != 0); i_we = cur[0].we;
      i_adr = cur[0].adr; i_dat_m = cur[0].dat; i_sel = cur[0].sel;
      d_cyc = (act[1] != 0); d_stb = (act[1] != 0); d_we = cur[1].we;
      d_adr = cur[1].adr; d_dat_m = cur[1].dat; d_sel = cur[1].sel;
    end
    tick(); tick();
    sb_on = 1'b0;
    chk("rand_in_budget", cyc_n < 5000, 1'b1);
    chk("served_i", served_i, NTX);
    chk("served_d", served_d, NTX);
    chk("sb_drained", q_i.size() + q_d.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
